passcode_ctrl: RTL and testbench
================================

// Module: passcode_ctrl
// PURPOSE
//  Keypad passcode controller: next generation of the push-button code entry block.
//  Accepts one-hot debounced button pulses and checks a variable-length code (DIGITS_MIN..DIGITS_MAX)
//  against a stored code; supports re-programming with double entry, inactivity timeout and
//  lockout after repeated failures. Sits between button debouncers and the lock/LED/7-seg logic.
// PARAMETERS
//  NUM_BTNS       6          digit buttons; button k enters digit value k+1
//  DW             4          bits per digit (must hold NUM_BTNS)
//  DIGITS_MIN     4          shortest accepted code length
//  DIGITS_MAX     6          longest code length / buffer depth
//  DEFAULT_CODE   24'h121212 reset code, DIGITS_MAX*DW bits, digit 0 in MSBs
//  DEFAULT_LEN    6          reset code length
//  MAX_FAILS      3          consecutive failed checks that trigger lockout
//  LOCKOUT_CYCLES 50_000_000 cycles spent in LOCK
//  TIMEOUT_CYCLES 100_000_000 inactivity cycles before an entry is abandoned
//  OPEN_CYCLES    250_000_000 cycles unlocked stays high if not cleared
// PORTS
//  clk        in  1                    single clock, rising edge
//  rst        in  1                    asynchronous, active-high reset
//  btn        in  NUM_BTNS             digit button pulses, one cycle per press
//  enter      in  1                    submit pulse
//  clear      in  1                    discard buffer / relock pulse
//  prog_req   in  1                    request code change (honoured only in OPEN)
//  unlocked   out 1                    high while in OPEN
//  locked_out out 1                    high while in LOCK
//  fail       out 1                    one-cycle pulse per failed check
//  prog_ok    out 1                    one-cycle pulse, new code stored
//  prog_err   out 1                    one-cycle pulse, new-code entries mismatched/invalid
//  digit_cnt  out $clog2(DIGITS_MAX+1) digits in the active buffer
//  state      out 3                    IDLE=0 ENTER=1 OPEN=2 NEW1=3 NEW2=4 LOCK=5
// BEHAVIOUR
//  Reset (async): state=IDLE, all outputs 0, buffers cleared, fail_cnt=0, code=DEFAULT_CODE/LEN.
//  Digit press: lowest-index set btn bit wins; digit shifts into buffer at index digit_cnt,
//   digit_cnt++ next cycle. Presses at digit_cnt==DIGITS_MAX are ignored (no wrap).
//  IDLE: first digit -> ENTER (digit captured). enter/clear in IDLE ignored.
//  ENTER: enter -> match iff digit_cnt==stored len and all digits equal.
//   match: OPEN, fail_cnt=0. mismatch or len outside MIN..MAX: fail pulse, fail_cnt++;
//   fail_cnt reaching MAX_FAILS -> LOCK, else IDLE. Buffer cleared either way.
//  OPEN: unlocked=1. clear or OPEN_CYCLES elapsed -> IDLE. prog_req -> NEW1.
//  NEW1: enter with valid length -> copy buffer+len to buf2, NEW2; invalid length -> prog_err, OPEN.
//  NEW2: enter: lengths and digits equal buf2 -> store code, prog_ok, IDLE; else prog_err, OPEN.
//  LOCK: all inputs ignored; after LOCKOUT_CYCLES -> IDLE, fail_cnt=0.
//  Timeout: counter reloads on any btn/enter/clear; TIMEOUT_CYCLES idle in ENTER/NEW1/NEW2
//   -> IDLE with buffers cleared, no fail pulse, fail_cnt unchanged.
//  clear in ENTER/NEW1/NEW2: buffer emptied, digit_cnt=0, state IDLE (NEW1/NEW2 -> OPEN).
//  Simultaneous: clear > enter > digit. enter+digit same cycle: enter checks the existing buffer,
//   digit dropped. prog_req outside OPEN ignored.
//  Reset mid-operation: programmed code lost, DEFAULT_CODE restored; pulses never stretch past 1 cycle.
//  Outputs registered; check result visible the cycle after enter.
// TESTING (defaults except LOCKOUT_CYCLES=20, TIMEOUT_CYCLES=50, OPEN_CYCLES=30)
//  1 btn idx 0,1,0,1,0,1 then enter -> next cycle unlocked=1, state=2; 30 cycles later unlocked=0.
//  2 digits 1,1,1,1 + enter three times -> fail pulses x3, locked_out=1 for 20 cycles, then IDLE;
//    digits during lock leave digit_cnt=0.
//  3 from OPEN: prog_req, 3,4,5,6 enter, 3,4,5,6 enter -> prog_ok; 3,4,5,6 enter -> unlocked=1;
//    old 121212 -> fail.
//  4 NEW1 3,4,5,6 / NEW2 3,4,5,5 -> prog_err, state OPEN, stored code still 121212.
//  5 seven digits then enter -> digit_cnt stays 6, code 121212 still matches;
//    three digits + enter -> fail.
//  6 two digits then 50 idle cycles -> state IDLE, digit_cnt 0, no fail; rst asserted mid-entry
//    -> all outputs 0 immediately, code 121212.

Source files
------------

// File: rtl/passcode_if.sv
// Keypad request lines and lock status for passcode_ctrl.
// The master side drives button, enter, clear and prog_req; the slave side reports status.
interface passcode_if #(
  parameter int NUM_BTNS = 6,
  parameter int CNT_W    = 3
);
  logic [NUM_BTNS-1:0] btn;
  logic                enter;
  logic                clear;
  logic                prog_req;
  logic                unlocked;
  logic                locked_out;
  logic                fail;
  logic                prog_ok;
  logic                prog_err;
  logic [CNT_W-1:0]    digit_cnt;
  logic [2:0]          state;

  modport master (
    output btn, enter, clear, prog_req,
    input  unlocked, locked_out, fail, prog_ok, prog_err, digit_cnt, state
  );

  modport slave (
    input  btn, enter, clear, prog_req,
    output unlocked, locked_out, fail, prog_ok, prog_err, digit_cnt, state
  );
endinterface

// File: rtl/passcode_ctrl.sv
// Keypad passcode controller: variable-length code check, double-entry reprogramming,
// inactivity timeout and lockout after repeated failures.
module passcode_ctrl #(
  parameter int                         NUM_BTNS       = 6,
  parameter int                         DW             = 4,
  parameter int                         DIGITS_MIN     = 4,
  parameter int                         DIGITS_MAX     = 6,
  parameter logic [DIGITS_MAX*DW-1:0]   DEFAULT_CODE   = 24'h121212,
  parameter int                         DEFAULT_LEN    = 6,
  parameter int                         MAX_FAILS      = 3,
  parameter int                         LOCKOUT_CYCLES = 50_000_000,
  parameter int                         TIMEOUT_CYCLES = 100_000_000,
  parameter int                         OPEN_CYCLES    = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  passcode_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTER = 3'd1,
    S_OPEN  = 3'd2,
    S_NEW1  = 3'd3,
    S_NEW2  = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  localparam int CW   = $clog2(DIGITS_MAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (OPEN_CYCLES > TIMEOUT_CYCLES)
                      ? ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
                      : ((TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] L_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] L_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] L_TO   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(DIGITS_MIN);
  localparam logic [CW-1:0] C_MAX  = CW'(DIGITS_MAX);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAILS);

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_buf  [DIGITS_MAX];
  logic [DW-1:0] r_buf2 [DIGITS_MAX];
  logic [DW-1:0] r_code [DIGITS_MAX];
  logic [CW-1:0] r_cnt, r_len2, r_len;
  logic [FW-1:0] r_fcnt, w_fcnt_nx;
  logic [TW-1:0] r_tmr;
  logic          r_fail, r_prog_ok, r_prog_err, r_unlocked, r_locked;

  logic [DW-1:0] w_dig;
  logic          w_press, w_act, w_entry_st, w_tmr_done;
  logic          w_match_code, w_match_buf2, w_len_ok;
  logic          w_take_dig, w_clr_buf, w_copy2, w_store;
  logic          w_fail, w_pok, w_perr;

  // Lowest-index pressed button wins; button k means digit k+1.
  always_comb begin
    w_dig = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--)
      if (bus.btn[i]) w_dig = DW'(i + 1);
  end

  assign w_press    = |bus.btn;
  assign w_act      = w_press | bus.enter | bus.clear;
  assign w_entry_st = (r_state == S_ENTER) || (r_state == S_NEW1) || (r_state == S_NEW2);
  assign w_len_ok   = (r_cnt >= C_MIN) && (r_cnt <= C_MAX);

  // Slots past the digit count are always zero, so whole-array compares are exact.
  always_comb begin
    w_match_code = (r_cnt == r_len);
    w_match_buf2 = (r_cnt == r_len2);
    for (int i = 0; i < DIGITS_MAX; i++) begin
      if (r_buf[i] != r_code[i]) w_match_code = 1'b0;
      if (r_buf[i] != r_buf2[i]) w_match_buf2 = 1'b0;
    end
  end

  always_comb begin
    case (r_state)
      S_OPEN:  w_tmr_done = (r_tmr == L_OPEN);
      S_LOCK:  w_tmr_done = (r_tmr == L_LOCK);
      default: w_tmr_done = (r_tmr == L_TO);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_fcnt_nx  = r_fcnt;
    w_take_dig = 1'b0;
    w_clr_buf  = 1'b0;
    w_copy2    = 1'b0;
    w_store    = 1'b0;
    w_fail     = 1'b0;
    w_pok      = 1'b0;
    w_perr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_take_dig = 1'b1;
          w_state_nx = S_ENTER;
        end
      end
      S_ENTER: begin
        if (bus.clear) begin
          w_clr_buf  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (bus.enter) begin
          w_clr_buf = 1'b1;
          if (w_match_code) begin
            w_fcnt_nx  = '0;
            w_state_nx = S_OPEN;
          end else begin
            w_fail     = 1'b1;
            w_fcnt_nx  = r_fcnt + 1'b1;
            w_state_nx = ((r_fcnt + 1'b1) == F_MAX) ? S_LOCK : S_IDLE;
          end
        end else if (w_press) begin
          w_take_dig = 1'b1;
        end else if (w_tmr_done) begin
          w_clr_buf  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_OPEN: begin
        if (bus.clear)          w_state_nx = S_IDLE;
        else if (bus.prog_req)  w_state_nx = S_NEW1;
        else if (w_tmr_done)    w_state_nx = S_IDLE;
      end
      S_NEW1, S_NEW2: begin
        if (bus.clear) begin
          w_clr_buf  = 1'b1;
          w_state_nx = S_OPEN;
        end else if (bus.enter) begin
          w_clr_buf = 1'b1;
          if (r_state == S_NEW1) begin
            w_copy2    = w_len_ok;
            w_perr     = !w_len_ok;
            w_state_nx = w_len_ok ? S_NEW2 : S_OPEN;
          end else begin
            w_store    = w_match_buf2;
            w_pok      = w_match_buf2;
            w_perr     = !w_match_buf2;
            w_state_nx = w_match_buf2 ? S_IDLE : S_OPEN;
          end
        end else if (w_press) begin
          w_take_dig = 1'b1;
        end else if (w_tmr_done) begin
          w_clr_buf  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_LOCK: begin
        if (w_tmr_done) begin
          w_fcnt_nx  = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // One timer serves OPEN hold, LOCK hold and entry inactivity; it restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len2     <= '0;
      r_len      <= CW'(DEFAULT_LEN);
      r_fcnt     <= '0;
      r_tmr      <= '0;
      r_fail     <= 1'b0;
      r_prog_ok  <= 1'b0;
      r_prog_err <= 1'b0;
      r_unlocked <= 1'b0;
      r_locked   <= 1'b0;
      for (int i = 0; i < DIGITS_MAX; i++) begin
        r_buf[i]  <= '0;
        r_buf2[i] <= '0;
        r_code[i] <= DEFAULT_CODE[(DIGITS_MAX-1-i)*DW +: DW];
      end
    end else begin
      r_fcnt     <= w_fcnt_nx;
      r_fail     <= w_fail;
      r_prog_ok  <= w_pok;
      r_prog_err <= w_perr;
      r_unlocked <= (w_state_nx == S_OPEN);
      r_locked   <= (w_state_nx == S_LOCK);
      if ((w_state_nx != r_state) || (w_act && w_entry_st)) r_tmr <= '0;
      else                                                  r_tmr <= r_tmr + 1'b1;
      if (w_clr_buf) begin
        r_cnt <= '0;
        for (int i = 0; i < DIGITS_MAX; i++) r_buf[i] <= '0;
      end else if (w_take_dig && (r_cnt < C_MAX)) begin
        r_buf[r_cnt] <= w_dig;
        r_cnt        <= r_cnt + 1'b1;
      end
      if (w_copy2) begin
        r_buf2 <= r_buf;
        r_len2 <= r_cnt;
      end
      if (w_store) begin
        r_code <= r_buf2;
        r_len  <= r_len2;
      end
    end
  end

  assign bus.unlocked   = r_unlocked;
  assign bus.locked_out = r_locked;
  assign bus.fail       = r_fail;
  assign bus.prog_ok    = r_prog_ok;
  assign bus.prog_err   = r_prog_err;
  assign bus.digit_cnt  = r_cnt;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_passcode_ctrl.sv
// Bench for passcode_ctrl: vector table, directed multi-cycle sequences and a
// randomized run checked against a queue-based behavioural model.
module tb_passcode_ctrl;
  localparam int LOCK_N = 20;
  localparam int TO_N   = 50;
  localparam int OPEN_N = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  passcode_if #(.NUM_BTNS(6), .CNT_W(3)) bus ();

  passcode_ctrl #(
    .LOCKOUT_CYCLES(LOCK_N),
    .TIMEOUT_CYCLES(TO_N),
    .OPEN_CYCLES(OPEN_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit seen_fail;

  // Observation packing: {unlocked, locked_out, fail, prog_ok, prog_err, digit_cnt[2:0], state[2:0]}
  function automatic logic [10:0] obs();
    return {bus.unlocked, bus.locked_out, bus.fail, bus.prog_ok, bus.prog_err,
            bus.digit_cnt, bus.state};
  endfunction

  function automatic logic [10:0] pk(input bit ul, lo, fl, ok, er, input int cnt, st);
    return {ul, lo, fl, ok, er, 3'(cnt), 3'(st)};
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ul/lo/fl/ok/er/cnt/st=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] b, input logic en, input logic clr, input logic pr);
    bus.btn = b; bus.enter = en; bus.clear = clr; bus.prog_req = pr;
    @(posedge clk); #1;
    bus.btn = '0; bus.enter = 1'b0; bus.clear = 1'b0; bus.prog_req = 1'b0;
    if (bus.fail) seen_fail = 1'b1;
  endtask

  task automatic dig(input int d);
    cyc(6'b1 << (d - 1), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic typ(input int q[$]);
    foreach (q[i]) dig(q[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_st, m_fails, m_age, m_quiet;
  int m_buf[$], m_buf2[$], m_code[$];
  bit m_fail, m_pok, m_perr;

  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_fails = 0; m_age = 0; m_quiet = 0;
    m_buf = {}; m_buf2 = {}; m_code = {1, 2, 1, 2, 1, 2};
    m_fail = 0; m_pok = 0; m_perr = 0;
  endtask

  task automatic model_step(input logic [5:0] b, input bit en, input bit clr, input bit pr);
    int d = 0;
    int nst;
    for (int k = 5; k >= 0; k--) if (b[k]) d = k + 1;
    nst = m_st; m_fail = 0; m_pok = 0; m_perr = 0;
    m_age++;
    m_quiet = ((d != 0) || en || clr) ? 0 : m_quiet + 1;
    case (m_st)
      0: if (d != 0) begin m_buf.push_back(d); nst = 1; end
      1: begin
        if (clr) begin m_buf = {}; nst = 0; end
        else if (en) begin
          if (same(m_buf, m_code)) begin m_fails = 0; nst = 2; end
          else begin m_fail = 1; m_fails++; nst = (m_fails == 3) ? 5 : 0; end
          m_buf = {};
        end else if (d != 0) begin if (m_buf.size() < 6) m_buf.push_back(d); end
        else if (m_quiet == TO_N) begin m_buf = {}; nst = 0; end
      end
      2: if (clr) nst = 0; else if (pr) nst = 3; else if (m_age == OPEN_N) nst = 0;
      3, 4: begin
        if (clr) begin m_buf = {}; nst = 2; end
        else if (en) begin
          if (m_st == 3) begin
            if (m_buf.size() >= 4 && m_buf.size() <= 6) begin m_buf2 = m_buf; nst = 4; end
            else begin m_perr = 1; nst = 2; end
          end else begin
            if (same(m_buf, m_buf2)) begin m_code = m_buf2; m_pok = 1; nst = 0; end
            else begin m_perr = 1; nst = 2; end
          end
          m_buf = {};
        end else if (d != 0) begin if (m_buf.size() < 6) m_buf.push_back(d); end
        else if (m_quiet == TO_N) begin m_buf = {}; nst = 0; end
      end
      5: if (m_age == LOCK_N) begin m_fails = 0; nst = 0; end
      default: nst = 0;
    endcase
    if (nst != m_st) begin m_age = 0; m_quiet = 0; end
    m_st = nst;
  endtask

  task automatic rcyc(input logic [5:0] b, input logic en, input logic clr, input logic pr);
    cyc(b, en, clr, pr);
    model_step(b, en, clr, pr);
    chk("random", obs(), pk(m_st == 2, m_st == 5, m_fail, m_pok, m_perr, m_buf.size(), m_st));
  endtask

  function automatic logic [5:0] dbtn(input int d);
    logic [5:0] one = 6'b1 << (d - 1);
    logic [5:0] hi  = ~((one << 1) - 6'd1);
    return ($urandom_range(0, 3) == 0) ? (one | (6'($urandom) & hi)) : one;
  endfunction

  task automatic do_reset();
    bus.btn = '0; bus.enter = 1'b0; bus.clear = 1'b0; bus.prog_req = 1'b0;
    rst = 1'b1;
    #2;
    chk("reset_outputs", obs(), 11'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  btn;
    logic        en, clr, pr;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] b, input bit en, clr, pr,
                              input bit ul, lo, fl, ok, er, input int cnt, st);
    vec_t v;
    v.btn = b; v.en = en; v.clr = clr; v.pr = pr;
    v.exp = pk(ul, lo, fl, ok, er, cnt, st);
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    tbl[0]  = mk(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[1]  = mk(6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    tbl[2]  = mk(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[3]  = mk(6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1);
    tbl[4]  = mk(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1);
    tbl[5]  = mk(6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1);
    tbl[6]  = mk(6'b000100, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2);  // enter+digit: digit dropped
    tbl[7]  = mk(6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[8]  = mk(6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    tbl[9]  = mk(6'b001000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
    tbl[10] = mk(6'b000000, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2);  // too short -> prog_err
    tbl[11] = mk(6'b000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(6'b110000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(6'b000000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // clear beats enter
    tbl[14] = mk(6'b000011, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[15] = mk(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    tbl[16] = mk(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[17] = mk(6'b000000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[18] = mk(6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(6'b000000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(6'b000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    #1;
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].btn, tbl[i].en, tbl[i].clr, tbl[i].pr);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // OPEN holds for OPEN_N cycles then relocks
    do_reset();
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("open_now", obs(), pk(1, 0, 0, 0, 0, 0, 2));
    idle(OPEN_N - 1);
    chk("open_last", obs(), pk(1, 0, 0, 0, 0, 0, 2));
    idle(1);
    chk("open_expired", obs(), pk(0, 0, 0, 0, 0, 0, 0));

    // Three failures lock out; LOCK ignores input and lasts LOCK_N cycles
    do_reset();
    for (int r = 0; r < 3; r++) begin
      typ('{1, 1, 1, 1});
      cyc('0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("fail%0d", r), obs(), pk(0, r == 2, 1, 0, 0, 0, (r == 2) ? 5 : 0));
    end
    typ('{1, 2, 3, 4, 5});
    cyc('0, 1'b1, 1'b1, 1'b1);
    chk("lock_ignores", obs(), pk(0, 1, 0, 0, 0, 0, 5));
    idle(LOCK_N - 7);
    chk("lock_last", obs(), pk(0, 1, 0, 0, 0, 0, 5));
    idle(1);
    chk("lock_release", obs(), pk(0, 0, 0, 0, 0, 0, 0));
    typ('{1, 1, 1, 1});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("fails_cleared", obs(), pk(0, 0, 1, 0, 0, 0, 0));

    // Reprogram to 3456, then new code opens and old one fails
    do_reset();
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    typ('{3, 4, 5, 6});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("prog_new2", obs(), pk(0, 0, 0, 0, 0, 0, 4));
    typ('{3, 4, 5, 6});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("prog_ok", obs(), pk(0, 0, 0, 1, 0, 0, 0));
    typ('{3, 4, 5, 6});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("new_code_opens", obs(), pk(1, 0, 0, 0, 0, 0, 2));
    cyc('0, 1'b0, 1'b1, 1'b0);
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("old_code_fails", obs(), pk(0, 0, 1, 0, 0, 0, 0));

    // Reset discards the programmed code
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("default_after_rst", obs(), pk(1, 0, 0, 0, 0, 0, 2));

    // Mismatched double entry keeps the old code
    do_reset();
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    typ('{3, 4, 5, 6});
    cyc('0, 1'b1, 1'b0, 1'b0);
    typ('{3, 4, 5, 5});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("prog_mismatch", obs(), pk(1, 0, 0, 0, 1, 0, 2));
    cyc('0, 1'b0, 1'b1, 1'b0);
    typ('{1, 2, 1, 2, 1, 2});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("code_kept", obs(), pk(1, 0, 0, 0, 0, 0, 2));

    // Buffer saturates at six digits; short code fails
    do_reset();
    typ('{1, 2, 1, 2, 1, 2, 1});
    chk("saturate", obs(), pk(0, 0, 0, 0, 0, 6, 1));
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("saturated_match", obs(), pk(1, 0, 0, 0, 0, 0, 2));
    cyc('0, 1'b0, 1'b1, 1'b0);
    typ('{1, 2, 1});
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("short_fails", obs(), pk(0, 0, 1, 0, 0, 0, 0));

    // Inactivity timeout abandons the entry quietly
    do_reset();
    seen_fail = 1'b0;
    typ('{1, 2});
    idle(TO_N - 5);
    chk("timeout_pending", obs(), pk(0, 0, 0, 0, 0, 2, 1));
    idle(5);
    chk("timeout_hit", obs(), pk(0, 0, 0, 0, 0, 0, 0));
    n_tests++;
    if (seen_fail) begin
      n_fail++;
      $display("FAIL timeout_no_fail: got fail pulse expected none");
    end

    // Asynchronous reset mid-entry clears outputs before the next edge
    typ('{1, 2, 1});
    #2 rst = 1'b1;
    #1 chk("async_rst", obs(), 11'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized run against the model
    do_reset();
    for (int t = 0; t < 300; t++) begin
      int kind = $urandom_range(0, 9);
      int q[$];
      int len;
      case (kind)
        0, 1, 2: begin
          q = m_code;
          foreach (q[i]) rcyc(dbtn(q[i]), 1'b0, 1'b0, 1'b0);
          rcyc('0, 1'b1, 1'b0, 1'b0);
        end
        3, 4: begin
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) rcyc(dbtn($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
          rcyc('0, 1'b1, 1'b0, 1'b0);
        end
        5: begin
          q = m_code;
          foreach (q[i]) rcyc(dbtn(q[i]), 1'b0, 1'b0, 1'b0);
          rcyc('0, 1'b1, 1'b0, 1'b0);
          rcyc('0, 1'b0, 1'b0, 1'b1);
          len = $urandom_range(3, 6);
          q = {};
          for (int i = 0; i < len; i++) q.push_back($urandom_range(1, 6));
          foreach (q[i]) rcyc(dbtn(q[i]), 1'b0, 1'b0, 1'b0);
          rcyc('0, 1'b1, 1'b0, 1'b0);
          if ($urandom_range(0, 2) == 0) q[0] = (q[0] % 6) + 1;
          foreach (q[i]) rcyc(dbtn(q[i]), 1'b0, 1'b0, 1'b0);
          rcyc('0, 1'b1, 1'b0, 1'b0);
        end
        6: begin
          len = $urandom_range(1, 60);
          for (int i = 0; i < len; i++) rcyc('0, 1'b0, 1'b0, 1'b0);
        end
        default: begin
          len = $urandom_range(1, 8);
          for (int i = 0; i < len; i++)
            rcyc(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
